// File: rtl/demux1to4_router.sv
// 1-to-4 router: steers each input word to one of four registered output channels, each holding its word until acked.
// Latency: 1 cycle from accepted input to out_valid on the destination channel.
// Backpressure: in_ready drops while the destination channel is full and not being acked in the same cycle.
//
// Ports:
//   clock, reset          rising-edge clock; asynchronous active-high reset
//   in_data/in_valid      input word and its strobe; in_ready reports whether it can be taken
//   sel, auto_mode        destination select ({sel[1],sel[0]}) or round-robin via ptr when auto_mode=1
//   out_data/out_valid    per-channel held word (channel i at [i*WIDTH +: WIDTH]) and sticky valid
//   out_ack               per-channel consume strobe
//   ptr                   round-robin pointer
module demux1to4_router #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         sel,
  input  logic               auto_mode,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ack,
  output logic [1:0]         ptr
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e        st_q   [4];
  ch_state_e        st_d   [4];
  logic [WIDTH-1:0] data_q [4];
  logic [1:0]       ptr_q;
  logic [1:0]       ptr_d;
  logic [1:0]       dest;
  logic             accept;
  logic [3:0]       load;

  // Ready is derived only from held state, the select path and the acks, so a
  // source may make in_valid depend on in_ready without forming a loop.
  always_comb begin
    dest     = auto_mode ? ptr_q : sel;
    in_ready = (st_q[dest] == EMPTY) | out_ack[dest];
    accept   = in_valid & in_ready;
    load     = 4'b0000;
    load[dest] = accept;
  end

  // Per-channel valid FSM. A refill in the same cycle as an ack keeps the
  // channel FULL, which is what gives one word per cycle per channel.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        EMPTY: if (load[i])                st_d[i] = FULL;
        FULL:  if (out_ack[i] && !load[i]) st_d[i] = EMPTY;
        default:                           st_d[i] = EMPTY;
      endcase
    end
  end

  // The pointer only moves on round-robin accepts; manual traffic leaves it
  // where it was so auto mode resumes in order.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && auto_mode) ptr_d = ptr_q + 2'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) st_q[i] <= EMPTY;
      ptr_q <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) st_q[i] <= st_d[i];
      ptr_q <= ptr_d;
    end
  end

  // Data is only ever overwritten by a new word; an ack leaves the last word visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) data_q[i] <= in_data;
      end
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      out_data[i*WIDTH +: WIDTH] = data_q[i];
      out_valid[i]               = (st_q[i] == FULL);
    end
  end

  assign ptr = ptr_q;

endmodule
